dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares the single-port data memory (dmemory4x8) between two requesters: port 0 is the CPU MEM stage and port 1 is the DMA/UART program-loader. The block arbitrates between the ports, drives the memory's write-enable, width, sign, address and data inputs, and returns the read data and bit_error to the requester that was granted. It also generates the CPU pipeline stall.

Parameters:
ADR_W, 16, memory byte-address width
DAT_W, 32, data width
MAX_WAIT, 4, number of consecutive lost arbitrations after which port 1 is forced a grant (only with DMEM_ARB_STARVE_EN); legal range 1..15

Ports:
clk_i  in  1  system clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
p0_req_i  in  1  CPU access request; held until p0_ack_o
p0_wen_i  in  1  CPU write enable (1 = store)
p0_width_i  in  2  access width: 0 = word, 1 = halfword, 3 = byte, 2 = reserved
p0_sign_i  in  1  sign-extend on narrow load
p0_adr_i  in  ADR_W  CPU byte address
p0_dat_i  in  DAT_W  CPU store data
p0_ack_o  out  1  one-cycle completion pulse
p0_rdat_o  out  DAT_W  load data, valid with p0_ack_o
p0_err_o  out  1  alignment/width error, valid with p0_ack_o
p0_stall_o  out  1  combinational stall: p0_req_i & ~p0_ack_o
p1_req_i, p1_wen_i, p1_width_i, p1_sign_i, p1_adr_i, p1_dat_i, p1_ack_o, p1_rdat_o, p1_err_o  same widths and semantics as port 0, for DMA
ram_wen_o  out  1  to memory write enable
ram_dat_width_o  out  2  to memory width
ram_sign_o  out  1  to memory sign
ram_adr_o  out  ADR_W  to memory address
ram_dat_o  out  DAT_W  to memory write data
ram_dat_i  in  DAT_W  from memory read data
ram_bit_error_i  in  1  from memory error flag

Behaviour:
- Memory contract: the memory samples address, width, sign, data and write-enable on the rising edge. Read data and bit_error are valid during the following cycle.
- FSM states: IDLE, ISSUE, RESP. Reset state is IDLE.
- IDLE: if any request is pending, latch the winner (owner register) and go to ISSUE. Otherwise stay in IDLE.
- ISSUE: drive the ram_* outputs from the owner's inputs, then go to RESP. ram_wen_o is high only in ISSUE and only when the owner's wen is 1.
- RESP: capture ram_dat_i into the owner's rdat register and ram_bit_error_i into its err register, assert the owner's ack for exactly one cycle, then return to IDLE. The access latency is therefore 3 cycles from req to ack (IDLE, ISSUE, RESP; ack is registered and visible in the cycle after RESP).
- Priority: port 0 wins whenever both ports request in IDLE, unless the starvation override applies (see Optional Feature).
- Request inputs are sampled only in IDLE. Changes to a requester's inputs while it is owner are ignored after the ISSUE edge, because its fields are latched on entry to ISSUE.
- When neither port is in ISSUE, ram_* outputs are 0 and ram_wen_o is 0.
- Width 2 is forwarded unchanged; the memory's bit_error is relayed to the requester.
- A store acks with rdat unchanged (it holds its previous value) and err taken from bit_error.
- A requester deasserting req before its ack is illegal. The arbiter still completes the access and pulses ack.
- Reset (asynchronous, at any time, including mid-access): FSM goes to IDLE, owner = 0, and all outputs go to 0 — acks, rdat, err, ram_*, and wait counter. An in-flight store is abandoned, and ram_wen_o drops immediately.

Optional Feature:
DMEM_ARB_STARVE_EN
- Defined: a 4-bit wait counter increments each time port 1 is requesting and port 0 wins in IDLE. The counter clears when port 1 is granted or when p1_req_i is low. When the count is >= MAX_WAIT, port 1 wins the next IDLE arbitration even if port 0 is requesting.
- Undefined: strict port-0 priority; no counter is built.

Test Plan:
- Reset: hold rst_n_i = 0 mid-ISSUE with p0_wen_i = 1 -> ram_wen_o = 0 immediately; all acks and rdat are 0; after release the FSM is in IDLE.
- Port 0 store then load: store word 0x00000007 at 0x0010, then load word at 0x0010 -> ram_wen_o high for one cycle; second ack has p0_rdat_o = 0x00000007 and p0_err_o = 0; p0_stall_o is high until each ack.
- Simultaneous requests: p0 load 0x0004 and p1 store 0x0008 in the same cycle -> p0_ack_o first; p1_ack_o follows 3 cycles later; no overlap between the two grants.
- Error relay: p1 halfword load at 0x0011 -> p1_err_o = 1 with p1_ack_o; p0 outputs untouched.
- Starvation, with DMEM_ARB_STARVE_EN defined and MAX_WAIT = 4: p0_req_i held high continuously and p1_req_i held high -> p1 is granted after exactly 4 port-0 grants. Without the macro, p1 is never granted while p0_req_i stays high.
- Sign/width pass-through: p0 byte load with sign = 1 at 0x0014 -> ram_dat_width_o = 3 and ram_sign_o = 1 during ISSUE; p0_rdat_o equals ram_dat_i as sampled in RESP.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter in front of the single-port data memory
//
// Shares dmemory4x8 between port 0 (CPU MEM stage) and port 1 (DMA/UART loader).
// Each access walks IDLE -> ISSUE -> RESP; ack is registered at the end of RESP.
//
// Parameters:
//   ADR_W     memory byte-address width
//   DAT_W     data width
//   MAX_WAIT  lost arbitrations before port 1 is forced a grant (1..15)
//
// Ports:
//   clk_i, rst_n_i             clock (rising edge), async active-low reset
//   pN_req_i/wen_i/width_i/    requester N access (held until pN_ack_o)
//   pN_sign_i/adr_i/dat_i
//   pN_ack_o/rdat_o/err_o      one-cycle completion, load data, error flag
//   p0_stall_o                 CPU pipeline stall (p0_req_i & ~p0_ack_o)
//   ram_*_o                    memory control/address/write data
//   ram_dat_i, ram_bit_error_i memory read data and error, valid the cycle after issue
//
// Optional feature macro: DMEM_ARB_STARVE_EN (port-1 starvation override).
module dmem_arbiter #(
  parameter int ADR_W    = 16,
  parameter int DAT_W    = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             p0_req_i,
  input  logic             p0_wen_i,
  input  logic [1:0]       p0_width_i,
  input  logic             p0_sign_i,
  input  logic [ADR_W-1:0] p0_adr_i,
  input  logic [DAT_W-1:0] p0_dat_i,
  output logic             p0_ack_o,
  output logic [DAT_W-1:0] p0_rdat_o,
  output logic             p0_err_o,
  output logic             p0_stall_o,
  input  logic             p1_req_i,
  input  logic             p1_wen_i,
  input  logic [1:0]       p1_width_i,
  input  logic             p1_sign_i,
  input  logic [ADR_W-1:0] p1_adr_i,
  input  logic [DAT_W-1:0] p1_dat_i,
  output logic             p1_ack_o,
  output logic [DAT_W-1:0] p1_rdat_o,
  output logic             p1_err_o,
  output logic             ram_wen_o,
  output logic [1:0]       ram_dat_width_o,
  output logic             ram_sign_o,
  output logic [ADR_W-1:0] ram_adr_o,
  output logic [DAT_W-1:0] ram_dat_o,
  input  logic [DAT_W-1:0] ram_dat_i,
  input  logic             ram_bit_error_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic             owner;
  logic             lat_wen;
  logic [1:0]       lat_width;
  logic             lat_sign;
  logic [ADR_W-1:0] lat_adr;
  logic [DAT_W-1:0] lat_dat;

  logic any_req;
  logic grant_p1;

  assign any_req = p0_req_i | p1_req_i;

`ifdef DMEM_ARB_STARVE_EN
  logic [3:0] wait_cnt;
  logic       starved;

  assign starved  = (wait_cnt >= 4'(MAX_WAIT));
  assign grant_p1 = p1_req_i & (~p0_req_i | starved);

  // Counts IDLE arbitrations that port 1 lost to port 0; any idle period
  // of port 1 or a port-1 grant restarts the count.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wait_cnt <= 4'd0;
    end else if (!p1_req_i) begin
      wait_cnt <= 4'd0;
    end else if (state == IDLE) begin
      if (grant_p1) begin
        wait_cnt <= 4'd0;
      end else if (wait_cnt != 4'hf) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end
  end
`else
  assign grant_p1 = p1_req_i & ~p0_req_i;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      owner     <= 1'b0;
      lat_wen   <= 1'b0;
      lat_width <= 2'd0;
      lat_sign  <= 1'b0;
      lat_adr   <= '0;
      lat_dat   <= '0;
      p0_ack_o  <= 1'b0;
      p0_rdat_o <= '0;
      p0_err_o  <= 1'b0;
      p1_ack_o  <= 1'b0;
      p1_rdat_o <= '0;
      p1_err_o  <= 1'b0;
    end else begin
      state    <= state_nxt;
      p0_ack_o <= 1'b0;
      p1_ack_o <= 1'b0;

      // The winner's request fields are frozen here so that later changes
      // by the requester cannot disturb the access in flight.
      if (state == IDLE && any_req) begin
        owner     <= grant_p1;
        lat_wen   <= grant_p1 ? p1_wen_i   : p0_wen_i;
        lat_width <= grant_p1 ? p1_width_i : p0_width_i;
        lat_sign  <= grant_p1 ? p1_sign_i  : p0_sign_i;
        lat_adr   <= grant_p1 ? p1_adr_i   : p0_adr_i;
        lat_dat   <= grant_p1 ? p1_dat_i   : p0_dat_i;
      end

      // Stores leave rdat untouched; error is relayed for both kinds.
      if (state == RESP) begin
        if (owner) begin
          p1_ack_o <= 1'b1;
          p1_err_o <= ram_bit_error_i;
          if (!lat_wen) p1_rdat_o <= ram_dat_i;
        end else begin
          p0_ack_o <= 1'b1;
          p0_err_o <= ram_bit_error_i;
          if (!lat_wen) p0_rdat_o <= ram_dat_i;
        end
      end
    end
  end

  // Memory side is quiet outside ISSUE; decoding from state makes an
  // asynchronous reset drop ram_wen_o without waiting for a clock.
  always_comb begin
    ram_wen_o       = 1'b0;
    ram_dat_width_o = 2'd0;
    ram_sign_o      = 1'b0;
    ram_adr_o       = '0;
    ram_dat_o       = '0;
    if (state == ISSUE) begin
      ram_wen_o       = lat_wen;
      ram_dat_width_o = lat_width;
      ram_sign_o      = lat_sign;
      ram_adr_o       = lat_adr;
      ram_dat_o       = lat_dat;
    end
  end

  assign p0_stall_o = p0_req_i & ~p0_ack_o;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  localparam int ADR_W = 16;
  localparam int DAT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             p0_req, p0_wen, p0_sign;
  logic [1:0]       p0_width;
  logic [ADR_W-1:0] p0_adr;
  logic [DAT_W-1:0] p0_dat;
  logic             p0_ack, p0_err, p0_stall;
  logic [DAT_W-1:0] p0_rdat;
  logic             p1_req, p1_wen, p1_sign;
  logic [1:0]       p1_width;
  logic [ADR_W-1:0] p1_adr;
  logic [DAT_W-1:0] p1_dat;
  logic             p1_ack, p1_err;
  logic [DAT_W-1:0] p1_rdat;
  logic             ram_wen, ram_sign;
  logic [1:0]       ram_width;
  logic [ADR_W-1:0] ram_adr;
  logic [DAT_W-1:0] ram_wdat;
  logic [DAT_W-1:0] ram_rdat;
  logic             ram_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADR_W(ADR_W), .DAT_W(DAT_W), .MAX_WAIT(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .p0_req_i(p0_req), .p0_wen_i(p0_wen), .p0_width_i(p0_width), .p0_sign_i(p0_sign),
    .p0_adr_i(p0_adr), .p0_dat_i(p0_dat), .p0_ack_o(p0_ack), .p0_rdat_o(p0_rdat),
    .p0_err_o(p0_err), .p0_stall_o(p0_stall),
    .p1_req_i(p1_req), .p1_wen_i(p1_wen), .p1_width_i(p1_width), .p1_sign_i(p1_sign),
    .p1_adr_i(p1_adr), .p1_dat_i(p1_dat), .p1_ack_o(p1_ack), .p1_rdat_o(p1_rdat),
    .p1_err_o(p1_err),
    .ram_wen_o(ram_wen), .ram_dat_width_o(ram_width), .ram_sign_o(ram_sign),
    .ram_adr_o(ram_adr), .ram_dat_o(ram_wdat), .ram_dat_i(ram_rdat),
    .ram_bit_error_i(ram_err)
  );

  // Stand-in for dmemory4x8: word stores, narrow little-endian loads,
  // read data and error valid the cycle after the sampling edge.
  logic [31:0] mem [0:63];

  function automatic logic [31:0] mem_read(input logic [31:0] w, input logic [1:0] width,
                                           input logic sgn, input logic [1:0] a);
    logic [15:0] h;
    logic [7:0]  b;
    h = a[1] ? w[31:16] : w[15:0];
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    case (width)
      2'd1:    return sgn ? {{16{h[15]}}, h} : {16'h0, h};
      2'd3:    return sgn ? {{24{b[7]}}, b} : {24'h0, b};
      default: return w;
    endcase
  endfunction

  always @(posedge clk) begin
    if (ram_wen) mem[ram_adr[7:2]] <= ram_wdat;
    ram_rdat <= mem_read(mem[ram_adr[7:2]], ram_width, ram_sign, ram_adr[1:0]);
    ram_err  <= (ram_width == 2'd2) || (ram_width == 2'd1 && ram_adr[0]) ||
                (ram_width == 2'd0 && ram_adr[1:0] != 2'd0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Values seen on the memory side during the first cycle after the request.
  logic [1:0]  iss_width;
  logic        iss_sign;
  logic [15:0] iss_adr;
  int          wen_cycles;

  // Called just after a negedge; returns the number of negedges until ack.
  task automatic access(input bit port, input logic wen, input logic [1:0] width,
                        input logic sgn, input logic [15:0] adr, input logic [31:0] dat,
                        output int lat);
    logic got;
    if (port) begin
      p1_wen = wen; p1_width = width; p1_sign = sgn; p1_adr = adr; p1_dat = dat; p1_req = 1'b1;
    end else begin
      p0_wen = wen; p0_width = width; p0_sign = sgn; p0_adr = adr; p0_dat = dat; p0_req = 1'b1;
    end
    lat = 0; wen_cycles = 0; got = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (ram_wen) wen_cycles++;
      if (lat == 1) begin
        iss_width = ram_width; iss_sign = ram_sign; iss_adr = ram_adr;
      end
      got = port ? p1_ack : p0_ack;
      if (!port) check("p0_stall", {31'd0, p0_stall}, {31'd0, ~got});
    end
    check("ack_seen", {31'd0, got}, 32'd1);
    p0_req = 1'b0;
    p1_req = 1'b0;
  endtask

  int lat, c0, c1, n0, n0_before, n1;
  logic overlap;

  initial begin
    rst_n = 1'b0;
    p0_req = 0; p0_wen = 0; p0_width = 0; p0_sign = 0; p0_adr = 0; p0_dat = 0;
    p1_req = 0; p1_wen = 0; p1_width = 0; p1_sign = 0; p1_adr = 0; p1_dat = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_p0_ack", {31'd0, p0_ack}, 32'd0);
    check("rst_p0_rdat", p0_rdat, 32'd0);
    check("rst_p1_rdat", p1_rdat, 32'd0);
    check("rst_ram_wen", {31'd0, ram_wen}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset arriving while a store is in ISSUE.
    p0_wen = 1; p0_width = 0; p0_adr = 16'h0020; p0_dat = 32'hdeadbeef; p0_req = 1;
    @(negedge clk);
    check("pre_rst_wen", {31'd0, ram_wen}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_wen_drop", {31'd0, ram_wen}, 32'd0);
    check("rst_adr_drop", {16'd0, ram_adr}, 32'd0);
    check("rst_mid_ack", {30'd0, p1_ack, p0_ack}, 32'd0);
    check("rst_mid_rdat", p0_rdat, 32'd0);
    p0_req = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Port 0 store then load.
    access(0, 1, 2'd0, 0, 16'h0010, 32'h00000007, lat);
    check("st_latency", lat, 32'd3);
    check("st_wen_cycles", wen_cycles, 32'd1);
    check("st_rdat_hold", p0_rdat, 32'd0);
    check("st_err", {31'd0, p0_err}, 32'd0);
    access(0, 0, 2'd0, 0, 16'h0010, 32'h0, lat);
    check("ld_latency", lat, 32'd3);
    check("ld_wen_cycles", wen_cycles, 32'd0);
    check("ld_rdat", p0_rdat, 32'h00000007);
    check("ld_err", {31'd0, p0_err}, 32'd0);
    access(0, 0, 2'd0, 0, 16'h0020, 32'h0, lat);
    check("abandoned_store", p0_rdat, 32'h00000000);

    // Byte load with sign extension.
    access(1, 1, 2'd0, 0, 16'h0014, 32'h123456f0, lat);
    check("p1_st_latency", lat, 32'd3);
    access(0, 0, 2'd3, 1, 16'h0014, 32'h0, lat);
    check("sb_width", {30'd0, iss_width}, 32'd3);
    check("sb_sign", {31'd0, iss_sign}, 32'd1);
    check("sb_adr", {16'd0, iss_adr}, 32'h0014);
    check("sb_rdat", p0_rdat, 32'hfffffff0);

    // Misaligned halfword on port 1.
    access(1, 0, 2'd1, 0, 16'h0011, 32'h0, lat);
    check("err_p1", {31'd0, p1_err}, 32'd1);
    check("err_p0_rdat", p0_rdat, 32'hfffffff0);
    check("err_p0_err", {31'd0, p0_err}, 32'd0);
    check("err_p0_ack", {31'd0, p0_ack}, 32'd0);

    // Both ports in the same cycle.
    p0_wen = 0; p0_width = 0; p0_sign = 0; p0_adr = 16'h0004; p0_req = 1;
    p1_wen = 1; p1_width = 0; p1_sign = 0; p1_adr = 16'h0008; p1_dat = 32'h00000055; p1_req = 1;
    c0 = 0; c1 = 0; overlap = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (p0_ack && p1_ack) overlap = 1;
      if (p0_ack) begin c0 = i; p0_req = 0; end
      if (p1_ack) begin c1 = i; p1_req = 0; end
    end
    check("sim_p0_ack_cycle", c0, 32'd3);
    check("sim_p1_ack_cycle", c1, 32'd6);
    check("sim_overlap", {31'd0, overlap}, 32'd0);
    access(0, 0, 2'd0, 0, 16'h0008, 32'h0, lat);
    check("sim_p1_store", p0_rdat, 32'h00000055);

    // Port 0 requesting back to back while port 1 waits.
    p0_wen = 0; p0_width = 0; p0_adr = 16'h0010; p0_req = 1;
    p1_wen = 0; p1_width = 0; p1_adr = 16'h0014; p1_req = 1;
    n0 = 0; n1 = 0; n0_before = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (p0_ack) n0++;
      if (p1_ack) begin
        n1++;
        if (n0_before < 0) n0_before = n0;
        p1_req = 0;
      end
    end
    p0_req = 0; p1_req = 0;
`ifdef DMEM_ARB_STARVE_EN
    check("starve_p1_grants", n1, 32'd1);
    check("starve_p0_before", n0_before, 32'd4);
`else
    check("strict_p1_grants", n1, 32'd0);
    check("strict_p0_grants", n0, 32'd20);
`endif
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
